// File: rtl/rotozoom_addr_gen_pkg.sv
// Shared constants and types for the rotozoom texture address generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rotozoom_addr_gen_pkg;

    // Accumulator width and fractional bits (Q10.8 two's complement).
    localparam int ACC_W  = 18;
    localparam int FRAC_W = 8;

    // A quarter turn in 256-step angle units. cos(a) is looked up as sin(a + QUARTER_TURN).
    localparam logic [7:0] QUARTER_TURN = 8'd64;

    typedef logic [ACC_W-1:0] acc_t;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        STEP,
        ORIGIN,
        RUN
    } state_e;

endpackage

// File: rtl/rotozoom_addr_gen_if.sv
// Parameter, timing and texel-coordinate bundle between video timing and texture fetch.
// Latency: n/a (wires only). Optional uv_oob signal under macro ROTOZOOM_OOB_EN.
// Backpressure: none; pix_en is a strobe and uv_valid a one-cycle qualifier.
interface rotozoom_addr_gen_if;

    logic [7:0] X_center;
    logic [7:0] Y_center;
    logic [7:0] Angle;
    logic [7:0] Zoom;
    logic       frame_start;
    logic       line_start;
    logic       pix_en;
    logic [7:0] u_out;
    logic [7:0] v_out;
    logic       uv_valid;
`ifdef ROTOZOOM_OOB_EN
    logic       uv_oob;
`endif

    // Upstream side: drives parameters and timing, observes coordinates.
    modport master (
        output X_center, Y_center, Angle, Zoom,
        output frame_start, line_start, pix_en,
`ifdef ROTOZOOM_OOB_EN
        input  uv_oob,
`endif
        input  u_out, v_out, uv_valid
    );

    // Address generator side.
    modport slave (
        input  X_center, Y_center, Angle, Zoom,
        input  frame_start, line_start, pix_en,
`ifdef ROTOZOOM_OOB_EN
        output uv_oob,
`endif
        output u_out, v_out, uv_valid
    );

endinterface

// File: rtl/rotozoom_addr_gen_sin_cos_lut.sv
// Signed 8-bit sine/cosine of a 256-step angle, amplitude 127, from a 64-entry quarter-wave ROM.
// Latency: 1 cycle (registered outputs).
// Backpressure: none; a new angle may be presented every cycle.
module sin_cos_lut
    import rotozoom_addr_gen_pkg::*;
(
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [7:0]        i_angle,
    output logic signed [7:0] o_cos,
    output logic signed [7:0] o_sin
);

    // round(127 * sin(2*pi*k/256)) for k = 0..63.
    function automatic logic [6:0] quarter_rom(input logic [5:0] k);
        logic [6:0] q;
        case (k)
            6'd0:  q = 7'd0;   6'd1:  q = 7'd3;   6'd2:  q = 7'd6;   6'd3:  q = 7'd9;
            6'd4:  q = 7'd12;  6'd5:  q = 7'd16;  6'd6:  q = 7'd19;  6'd7:  q = 7'd22;
            6'd8:  q = 7'd25;  6'd9:  q = 7'd28;  6'd10: q = 7'd31;  6'd11: q = 7'd34;
            6'd12: q = 7'd37;  6'd13: q = 7'd40;  6'd14: q = 7'd43;  6'd15: q = 7'd46;
            6'd16: q = 7'd49;  6'd17: q = 7'd51;  6'd18: q = 7'd54;  6'd19: q = 7'd57;
            6'd20: q = 7'd60;  6'd21: q = 7'd63;  6'd22: q = 7'd65;  6'd23: q = 7'd68;
            6'd24: q = 7'd71;  6'd25: q = 7'd73;  6'd26: q = 7'd76;  6'd27: q = 7'd78;
            6'd28: q = 7'd81;  6'd29: q = 7'd83;  6'd30: q = 7'd85;  6'd31: q = 7'd88;
            6'd32: q = 7'd90;  6'd33: q = 7'd92;  6'd34: q = 7'd94;  6'd35: q = 7'd96;
            6'd36: q = 7'd98;  6'd37: q = 7'd100; 6'd38: q = 7'd102; 6'd39: q = 7'd104;
            6'd40: q = 7'd106; 6'd41: q = 7'd107; 6'd42: q = 7'd109; 6'd43: q = 7'd111;
            6'd44: q = 7'd112; 6'd45: q = 7'd113; 6'd46: q = 7'd115; 6'd47: q = 7'd116;
            6'd48: q = 7'd117; 6'd49: q = 7'd118; 6'd50: q = 7'd120; 6'd51: q = 7'd121;
            6'd52: q = 7'd122; 6'd53: q = 7'd122; 6'd54: q = 7'd123; 6'd55: q = 7'd124;
            6'd56: q = 7'd125; 6'd57: q = 7'd125; 6'd58: q = 7'd126; 6'd59: q = 7'd126;
            6'd60: q = 7'd126; 6'd61: q = 7'd127; 6'd62: q = 7'd127; 6'd63: q = 7'd127;
            default: q = 7'd0;
        endcase
        return q;
    endfunction

    // Quadrant folding: odd quadrants mirror the index (64 - k, where k = 64 is the peak
    // that the 64-entry table cannot hold), the lower half-turn negates.
    function automatic logic signed [7:0] fold_sin(input logic [7:0] a);
        logic [6:0] k;
        logic [6:0] mag;
        k   = a[6] ? (7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
        mag = (k == 7'd64) ? 7'd127 : quarter_rom(k[5:0]);
        return a[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    logic signed [7:0] w_sin;
    logic signed [7:0] w_cos;

    // Combinational ROM lookups for both functions of the same angle.
    always_comb begin
        w_sin = fold_sin(i_angle);
        w_cos = fold_sin(i_angle + QUARTER_TURN);
    end

    // Output register gives the single cycle of lookup latency.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            o_sin <= '0;
            o_cos <= '0;
        end else begin
            o_sin <= w_sin;
            o_cos <= w_cos;
        end
    end

endmodule

// File: rtl/rotozoom_addr_gen.sv
// Per-pixel rotated/zoomed texture coordinate generator; parameters sampled at frame_start.
// Latency: 1 cycle from accepted pix_en to uv_valid; 4 cycles of per-frame setup. Macro ROTOZOOM_OOB_EN adds uv_oob.
// Backpressure: none; pix_en/line_start are strobes, ignored outside RUN, frame_start restarts at any time.
module rotozoom_addr_gen
    import rotozoom_addr_gen_pkg::*;
#(
    parameter int H_HALF = 160,
    parameter int V_HALF = 120
)(
    input  logic                  ACLK,
    input  logic                  ARESETn,
    rotozoom_addr_gen_if.slave    bus
);

    localparam acc_t H_HALF_A = acc_t'(H_HALF);
    localparam acc_t V_HALF_A = acc_t'(V_HALF);

    state_e r_state;
    state_e w_next_state;
    logic   w_line_acc;
    logic   w_pix_acc;

    // Frame parameters captured together with frame_start.
    logic [7:0] r_xc;
    logic [7:0] r_yc;
    logic [7:0] r_zoom;
    logic [7:0] r_angle;

    logic signed [7:0]  w_lut_cos;
    logic signed [7:0]  w_lut_sin;
    logic signed [16:0] w_cz;
    logic signed [16:0] w_sz;

    // Per-pixel steps (C along the line, S across it) and the running coordinates.
    acc_t r_c;
    acc_t r_s;
    acc_t w_row_u0;
    acc_t w_row_v0;
    acc_t r_row_u;
    acc_t r_row_v;
    acc_t r_u_acc;
    acc_t r_v_acc;

    logic [7:0] r_u_out;
    logic [7:0] r_v_out;
    logic       r_uv_valid;
`ifdef ROTOZOOM_OOB_EN
    logic       r_uv_oob;
`endif

    sin_cos_lut u_lut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .i_angle (r_angle),
        .o_cos   (w_lut_cos),
        .o_sin   (w_lut_sin)
    );

    // trig * Zoom fits in 17 signed bits; >>>3 turns 127*Q4.4 into Q.8 texels per pixel.
    assign w_cz = $signed({{9{w_lut_cos[7]}}, w_lut_cos}) * $signed({9'd0, r_zoom});
    assign w_sz = $signed({{9{w_lut_sin[7]}}, w_lut_sin}) * $signed({9'd0, r_zoom});

    // Top-left corner of the frame: centre minus half a screen along both rotated axes.
    // All terms wrap mod 2^18, which is exact for the low bits of the signed result.
    assign w_row_u0 = {2'b00, r_xc, 8'h00} - H_HALF_A * r_c + V_HALF_A * r_s;
    assign w_row_v0 = {2'b00, r_yc, 8'h00} - H_HALF_A * r_s - V_HALF_A * r_c;

    // State register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and strobe qualification; frame_start overrides everything.
    always_comb begin
        w_next_state = r_state;
        w_line_acc   = 1'b0;
        w_pix_acc    = 1'b0;
        case (r_state)
            IDLE:    w_next_state = IDLE;
            LATCH:   w_next_state = STEP;
            STEP:    w_next_state = ORIGIN;
            ORIGIN:  w_next_state = RUN;
            RUN: begin
                w_line_acc = bus.line_start;
                w_pix_acc  = bus.pix_en && !bus.line_start;
            end
            default: w_next_state = IDLE;
        endcase
        if (bus.frame_start) begin
            w_next_state = LATCH;
            w_line_acc   = 1'b0;
            w_pix_acc    = 1'b0;
        end
    end

    // Capture the frame parameters on frame_start so the LUT sees the angle during LATCH.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_xc    <= '0;
            r_yc    <= '0;
            r_zoom  <= '0;
            r_angle <= '0;
        end else if (bus.frame_start) begin
            r_xc    <= bus.X_center;
            r_yc    <= bus.Y_center;
            r_zoom  <= bus.Zoom;
            r_angle <= bus.Angle;
        end
    end

    // Scale the LUT outputs into per-pixel steps while in STEP.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_c <= '0;
            r_s <= '0;
        end else if (r_state == STEP) begin
            r_c <= acc_t'(w_cz >>> 3);
            r_s <= acc_t'(w_sz >>> 3);
        end
    end

    // Row origin set up in ORIGIN, then stepped per line; pixel accumulators stepped per pixel.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_row_u <= '0;
            r_row_v <= '0;
            r_u_acc <= '0;
            r_v_acc <= '0;
        end else if (r_state == ORIGIN) begin
            r_row_u <= w_row_u0;
            r_row_v <= w_row_v0;
        end else if (w_line_acc) begin
            r_u_acc <= r_row_u;
            r_v_acc <= r_row_v;
            r_row_u <= r_row_u - r_s;
            r_row_v <= r_row_v + r_c;
        end else if (w_pix_acc) begin
            r_u_acc <= r_u_acc + r_c;
            r_v_acc <= r_v_acc + r_s;
        end
    end

    // Present the integer texel of the current accumulators one cycle after pix_en.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_u_out    <= '0;
            r_v_out    <= '0;
            r_uv_valid <= 1'b0;
`ifdef ROTOZOOM_OOB_EN
            r_uv_oob   <= 1'b0;
`endif
        end else begin
            r_uv_valid <= w_pix_acc;
`ifdef ROTOZOOM_OOB_EN
            // Anything outside the 0..255 texel window shows up in the two top integer bits.
            r_uv_oob   <= w_pix_acc &&
                          ((r_u_acc[ACC_W-1:ACC_W-2] != 2'b00) || (r_v_acc[ACC_W-1:ACC_W-2] != 2'b00));
`endif
            if (w_pix_acc) begin
                r_u_out <= r_u_acc[FRAC_W+7:FRAC_W];
                r_v_out <= r_v_acc[FRAC_W+7:FRAC_W];
            end
        end
    end

    assign bus.u_out    = r_u_out;
    assign bus.v_out    = r_v_out;
    assign bus.uv_valid = r_uv_valid;
`ifdef ROTOZOOM_OOB_EN
    assign bus.uv_oob   = r_uv_oob;
`endif

endmodule

// File: tb/tb_rotozoom_addr_gen.sv
// Self-checking bench for rotozoom_addr_gen: trig-based reference model feeding a scoreboard.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Build with ROTOZOOM_OOB_EN defined to also exercise uv_oob.
module tb_rotozoom_addr_gen;

    logic ACLK = 1'b0;
    logic ARESETn;

    rotozoom_addr_gen_if bus();

    rotozoom_addr_gen dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [7:0] u;
        logic [7:0] v;
        logic       oob;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk   = 0;
    int   n_err   = 0;
    int   n_valid = 0;

    // Reference model state (18-bit wrap-around arithmetic).
    logic [17:0] m_c, m_s, m_row_u, m_row_v, m_u, m_v;

    function automatic int trig127(input int a, input bit is_sin);
        real ang;
        real r;
        ang = 2.0 * 3.14159265358979 * a / 256.0;
        r   = 127.0 * (is_sin ? $sin(ang) : $cos(ang));
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_frame(input logic [7:0] xc, input logic [7:0] yc,
                            input logic [7:0] ang, input logic [7:0] zm, input int settle);
        int c, s, x, y, z, a;
        x = xc; y = yc; z = zm; a = ang;
        bus.X_center    = xc;
        bus.Y_center    = yc;
        bus.Angle       = ang;
        bus.Zoom        = zm;
        bus.frame_start = 1'b1;
        c = (trig127(a, 1'b0) * z) >>> 3;
        s = (trig127(a, 1'b1) * z) >>> 3;
        m_c     = 18'(c);
        m_s     = 18'(s);
        m_row_u = 18'(x * 256 - 160 * c + 120 * s);
        m_row_v = 18'(y * 256 - 160 * s - 120 * c);
        tick();
        bus.frame_start = 1'b0;
        repeat (settle) tick();
    endtask

    task automatic do_line(input bit with_pix);
        bus.line_start = 1'b1;
        bus.pix_en     = with_pix;
        m_u     = m_row_u;
        m_v     = m_row_v;
        m_row_u = m_row_u - m_s;
        m_row_v = m_row_v + m_c;
        tick();
        bus.line_start = 1'b0;
        bus.pix_en     = 1'b0;
    endtask

    task automatic do_pix(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            bus.pix_en = 1'b1;
            e.u   = m_u[15:8];
            e.v   = m_v[15:8];
            e.oob = (m_u[17:16] != 2'b00) || (m_v[17:16] != 2'b00);
            exp_q.push_back(e);
            m_u = m_u + m_c;
            m_v = m_v + m_s;
            tick();
        end
        bus.pix_en = 1'b0;
    endtask

    // Scoreboard: every uv_valid pops one expected coordinate.
    always @(negedge ACLK) begin
        if (ARESETn === 1'b1 && bus.uv_valid === 1'b1) begin
            n_valid++;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got u=%h v=%h, required no output", bus.u_out, bus.v_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.u_out !== mon_e.u || bus.v_out !== mon_e.v) begin
                    n_err++;
                    $display("FAIL pixel_uv: got (%h,%h), required (%h,%h)",
                             bus.u_out, bus.v_out, mon_e.u, mon_e.v);
                end
`ifdef ROTOZOOM_OOB_EN
                n_chk++;
                if (bus.uv_oob !== mon_e.oob) begin
                    n_err++;
                    $display("FAIL pixel_oob: got %b, required %b", bus.uv_oob, mon_e.oob);
                end
`endif
            end
        end
    end

    task automatic test_reset;
        ARESETn = 1'b0;
        repeat (3) tick();
        n_chk++;
        if (bus.u_out !== 8'h00) begin n_err++; $display("FAIL reset_u: got %h, required 00", bus.u_out); end
        n_chk++;
        if (bus.v_out !== 8'h00) begin n_err++; $display("FAIL reset_v: got %h, required 00", bus.v_out); end
        n_chk++;
        if (bus.uv_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", bus.uv_valid); end
        ARESETn = 1'b1;
        tick();
    endtask

    task automatic test_rotation0;
        int v0;
        v0 = n_valid;
        do_frame(8'h80, 8'h80, 8'h00, 8'h10, 3);
        do_line(1'b0);
        do_pix(2);
        tick(); tick();
        n_chk++;
        if (bus.u_out !== 8'hE2) begin n_err++; $display("FAIL rot0_u1: got %h, required e2", bus.u_out); end
        n_chk++;
        if (bus.v_out !== 8'h08) begin n_err++; $display("FAIL rot0_v1: got %h, required 08", bus.v_out); end
        n_chk++;
        if (n_valid - v0 != 2) begin n_err++; $display("FAIL rot0_valid_count: got %0d, required 2", n_valid - v0); end
        n_chk++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL rot0_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_quarter;
        int v0;
        v0 = n_valid;
        do_frame(8'h80, 8'h80, 8'h40, 8'h10, 3);
        do_line(1'b0);
        do_pix(3);
        tick();
        n_chk++;
        if (bus.v_out !== 8'hE3) begin n_err++; $display("FAIL quarter_v2: got %h, required e3", bus.v_out); end
        do_line(1'b1);          // simultaneous pix_en must be dropped
        do_pix(1);
        tick(); tick();
        n_chk++;
        if (bus.u_out !== 8'hF6) begin n_err++; $display("FAIL quarter_line2_u: got %h, required f6", bus.u_out); end
        n_chk++;
        if (bus.v_out !== 8'hE1) begin n_err++; $display("FAIL quarter_line2_v: got %h, required e1", bus.v_out); end
        n_chk++;
        if (n_valid - v0 != 4) begin n_err++; $display("FAIL quarter_valid_count: got %0d, required 4", n_valid - v0); end
        n_chk++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL quarter_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_zoom0;
        int v0;
        v0 = n_valid;
        do_frame(8'h80, 8'h80, 8'h25, 8'h00, 3);
        do_line(1'b0); do_pix(4);
        tick();
        do_line(1'b0); do_pix(3);
        do_line(1'b0); do_pix(3);
        tick(); tick();
        n_chk++;
        if (bus.u_out !== 8'h80 || bus.v_out !== 8'h80) begin
            n_err++; $display("FAIL zoom0_last: got (%h,%h), required (80,80)", bus.u_out, bus.v_out);
        end
        n_chk++;
        if (n_valid - v0 != 10) begin n_err++; $display("FAIL zoom0_valid_count: got %0d, required 10", n_valid - v0); end
        n_chk++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL zoom0_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_midframe;
        int v0;
        do_frame(8'h80, 8'h80, 8'h00, 8'h10, 3);
        do_line(1'b0);
        do_pix(3);
        bus.pix_en = 1'b1;      // held through frame_start and the three setup cycles
        do_frame(8'h80, 8'h80, 8'h40, 8'h10, 0);
        v0 = n_valid;
        n_chk++;
        if (bus.uv_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid_cleared: got %b, required 0", bus.uv_valid); end
        repeat (3) tick();
        bus.pix_en = 1'b0;
        n_chk++;
        if (n_valid - v0 != 0) begin n_err++; $display("FAIL mid_ignored: got %0d outputs, required 0", n_valid - v0); end
        do_line(1'b0);
        do_pix(2);
        tick(); tick();
        n_chk++;
        if (bus.u_out !== 8'hF7 || bus.v_out !== 8'hE2) begin
            n_err++; $display("FAIL mid_new_params: got (%h,%h), required (f7,e2)", bus.u_out, bus.v_out);
        end
        n_chk++;
        if (n_valid - v0 != 2) begin n_err++; $display("FAIL mid_valid_count: got %0d, required 2", n_valid - v0); end
        n_chk++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL mid_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_burst;
        int v0;
        do_frame(8'h80, 8'h80, 8'h20, 8'h10, 3);
        do_line(1'b0);
        do_pix(3);
        bus.pix_en = 1'b1;
        #2;
        ARESETn = 1'b0;
        exp_q.delete();
        #1;
        n_chk++;
        if (bus.u_out !== 8'h00 || bus.v_out !== 8'h00) begin
            n_err++; $display("FAIL rst_async_uv: got (%h,%h), required (00,00)", bus.u_out, bus.v_out);
        end
        n_chk++;
        if (bus.uv_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid: got %b, required 0", bus.uv_valid); end
        bus.pix_en = 1'b0;
        tick(); tick();
        ARESETn = 1'b1;
        v0 = n_valid;
        bus.line_start = 1'b1;
        tick();
        bus.line_start = 1'b0;
        bus.pix_en = 1'b1;
        repeat (4) tick();
        bus.pix_en = 1'b0;
        tick(); tick();
        n_chk++;
        if (n_valid - v0 != 0) begin n_err++; $display("FAIL rst_no_output: got %0d outputs, required 0", n_valid - v0); end
        n_chk++;
        if (bus.u_out !== 8'h00) begin n_err++; $display("FAIL rst_u_held: got %h, required 00", bus.u_out); end
        do_frame(8'h80, 8'h80, 8'h00, 8'h10, 3);
        do_line(1'b0);
        do_pix(2);
        tick(); tick();
        n_chk++;
        if (n_valid - v0 != 2) begin n_err++; $display("FAIL rst_recover_count: got %0d, required 2", n_valid - v0); end
        n_chk++;
        if (bus.u_out !== 8'hE2) begin n_err++; $display("FAIL rst_recover_u: got %h, required e2", bus.u_out); end
        n_chk++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL rst_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

`ifdef ROTOZOOM_OOB_EN
    task automatic test_oob;
        do_frame(8'h00, 8'h80, 8'h00, 8'h10, 3);
        do_line(1'b0);
        do_pix(1);
        tick(); tick();
        n_chk++;
        if (bus.u_out !== 8'h61) begin n_err++; $display("FAIL oob_u: got %h, required 61", bus.u_out); end
        n_chk++;
        if (bus.uv_oob !== 1'b0) begin n_err++; $display("FAIL oob_idle: got %b, required 0", bus.uv_oob); end
        do_frame(8'h80, 8'h80, 8'h00, 8'h10, 3);
        do_line(1'b0);
        do_pix(161);
        tick(); tick();
        n_chk++;
        if (bus.u_out !== 8'h80 || bus.v_out !== 8'h08) begin
            n_err++; $display("FAIL oob_centre: got (%h,%h), required (80,08)", bus.u_out, bus.v_out);
        end
        n_chk++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL oob_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask
`endif

    initial begin
        ARESETn         = 1'b0;
        bus.X_center    = '0;
        bus.Y_center    = '0;
        bus.Angle       = '0;
        bus.Zoom        = '0;
        bus.frame_start = 1'b0;
        bus.line_start  = 1'b0;
        bus.pix_en      = 1'b0;
        test_reset();
        test_rotation0();
        test_quarter();
        test_zoom0();
        test_midframe();
        test_reset_burst();
`ifdef ROTOZOOM_OOB_EN
        test_oob();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
